// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: bundles every non-clock signal of the systolic array
// sequencer.
//   slave  : the sequencer side (systolic_ctrl)
//   master : the environment side (command source, operand buffers, array, result consumer)
// Signals:
//   start/k_len            command in       busy/done           status out
//   buf_rd_en/buf_addr     buffer read out  a_rdata/b_rdata     buffer data in
//   arr_clr/arr_in_a/b     array feed out   arr_out_c           array result in
//   res_valid/res_data     result out       res_ready           result accept in
interface systolic_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] k_len;
  logic              busy;
  logic              done;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [31:0]       a_rdata;
  logic [31:0]       b_rdata;
  logic              arr_clr;
  logic [31:0]       arr_in_a;
  logic [31:0]       arr_in_b;
  logic [127:0]      arr_out_c;
  logic              res_valid;
  logic              res_ready;
  logic [127:0]      res_data;

  modport slave (
    input  start, k_len, a_rdata, b_rdata, arr_out_c, res_ready,
    output busy, done, buf_rd_en, buf_addr, arr_clr, arr_in_a, arr_in_b,
           res_valid, res_data
  );

  modport master (
    output start, k_len, a_rdata, b_rdata, arr_out_c, res_ready,
    input  busy, done, buf_rd_en, buf_addr, arr_clr, arr_in_a, arr_in_b,
           res_valid, res_data
  );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for the 4x4 int8 output-stationary systolic array.
// A job clears the PE accumulators, streams k_len operand words from the
// buffers into the array with a per-lane diagonal skew, lets the array drain,
// then captures the 128-bit result and offers it on a valid/ready port.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, ACTIVE-HIGH (1 = reset) despite its name
//   bus   : systolic_ctrl_if.slave carrying command, buffer, array and result signals
module systolic_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = 10
) (
  input logic           clk,
  input logic           rst_n,
  systolic_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_k_len;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_drain_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic              r_clr;
  logic              r_res_valid;
  logic [127:0]      r_res_data;

  // Job sequencer with registered control outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_k_len     <= {ADDR_W{1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_drain_cnt <= {CNT_W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_clr       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= 128'h0;
    end else begin
      r_done <= 1'b0;
      r_clr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is not taken; the next
          // job can begin from the cycle after done.
          if (bus.start && !r_done) begin
            r_k_len <= bus.k_len;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
            r_state <= S_CLEAR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (r_k_len == {ADDR_W{1'b0}}) begin
            r_drain_cnt <= DRAIN_LOAD;
            r_state     <= S_DRAIN;
          end else begin
            r_rd_en <= 1'b1;
            r_addr  <= {ADDR_W{1'b0}};
            r_state <= S_FEED;
          end
        end
        S_FEED: begin
          // k_len is non-zero here, so k_len-1 never underflows
          if (r_addr == r_k_len - ADDR_W'(1)) begin
            r_rd_en     <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_drain_cnt <= DRAIN_LOAD;
            r_state     <= S_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == {CNT_W{1'b0}}) begin
            r_res_data  <= bus.arr_out_c;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_drain_cnt <= r_drain_cnt - CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_OUT;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_rd_en     <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Skew datapath: lane j carries j+1 register stages after the read data
  logic             r_rd_vld;
  logic [7:0]       r_a_l0, r_b_l0;
  logic [1:0][7:0]  r_a_l1, r_b_l1;
  logic [2:0][7:0]  r_a_l2, r_b_l2;
  logic [3:0][7:0]  r_a_l3, r_b_l3;
  logic [31:0]      w_a_new;
  logic [31:0]      w_b_new;

  // Idle slots inject zeros so the array accumulates nothing from them
  assign w_a_new = r_rd_vld ? bus.a_rdata : 32'h0;
  assign w_b_new = r_rd_vld ? bus.b_rdata : 32'h0;

  // Read-valid flag and per-lane delay chains
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_rd_vld <= 1'b0;
      r_a_l0   <= 8'h0;
      r_b_l0   <= 8'h0;
      r_a_l1   <= 16'h0;
      r_b_l1   <= 16'h0;
      r_a_l2   <= 24'h0;
      r_b_l2   <= 24'h0;
      r_a_l3   <= 32'h0;
      r_b_l3   <= 32'h0;
    end else begin
      r_rd_vld <= r_rd_en;
      r_a_l0   <= w_a_new[31:24];
      r_b_l0   <= w_b_new[31:24];
      r_a_l1   <= {r_a_l1[0], w_a_new[23:16]};
      r_b_l1   <= {r_b_l1[0], w_b_new[23:16]};
      r_a_l2   <= {r_a_l2[1:0], w_a_new[15:8]};
      r_b_l2   <= {r_b_l2[1:0], w_b_new[15:8]};
      r_a_l3   <= {r_a_l3[2:0], w_a_new[7:0]};
      r_b_l3   <= {r_b_l3[2:0], w_b_new[7:0]};
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.buf_rd_en = r_rd_en;
  assign bus.buf_addr  = r_addr;
  assign bus.arr_clr   = r_clr;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.arr_in_a  = {r_a_l0, r_a_l1[1], r_a_l2[2], r_a_l3[3]};
  assign bus.arr_in_b  = {r_b_l0, r_b_l1[1], r_b_l2[2], r_b_l3[3]};

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
Sequencer for the 4x4 int8 output-stationary systolic array. On a start command it clears the PE accumulators and streams k_len words of A and B from the operand buffers into the array. It applies the per-lane diagonal skew, waits for the array to drain, then captures the 128-bit result row and offers it on a valid/ready port. It sits between the operand buffers and the array.

Parameters:
ADDR_W, 8, operand buffer address width; k_len range is 0..2^ADDR_W-1
DRAIN_CYC, 10, zero-feed cycles after the last buffer read before the result is captured (covers skew 3 + read/skew regs 2 + array propagation 4 + margin)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-high (1 = reset, despite the name)
start  input  1  start request; sampled only in IDLE
k_len  input  ADDR_W  number of K steps (buffer words); latched on accepted start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on the result handshake
buf_rd_en  output  1  buffer read strobe
buf_addr  output  ADDR_W  buffer read address
a_rdata  input  32  A word, valid the cycle after buf_rd_en; lane j = bits [31-8j -: 8]
b_rdata  input  32  B word, same timing and lane map
arr_clr  output  1  clears all PE accumulators
arr_in_a  output  32  skewed A stream to the array
arr_in_b  output  32  skewed B stream to the array
arr_out_c  input  128  array result
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
res_data  output  128  captured result

Behaviour:
- Reset (async, active-high): state = IDLE. All outputs 0: busy, done, buf_rd_en, buf_addr, arr_clr, arr_in_a, arr_in_b, res_valid, res_data. All skew registers 0. Reset mid-operation abandons the job with no done pulse.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> OUT -> IDLE.
- IDLE: start=1 latches k_len and moves to CLEAR.
- CLEAR: exactly 1 cycle with arr_clr=1. Next state is FEED, or DRAIN if k_len=0.
- FEED: exactly k_len cycles with buf_rd_en=1 and buf_addr = 0, 1, …, k_len-1. Then DRAIN.
- DRAIN: DRAIN_CYC cycles, no reads. Then OUT.
- OUT: on entry, res_data <= arr_out_c and res_valid=1. res_data is held stable until res_valid & res_ready. On that cycle: res_valid->0, done=1 for one cycle, next state IDLE.
- start is ignored whenever busy=1, including in the handshake cycle. A new start is accepted no earlier than the cycle after done.
- Skew datapath:
  - A read-valid flag is registered 1 cycle after buf_rd_en.
  - Lane j of arr_in_a/arr_in_b is the rdata lane j word delayed (1+j) cycles after its rdata cycle.
  - A word addressed in cycle c therefore reaches arr_in lane j at cycle c+2+j.
  - Lane 0 = bits [31:24], lane 3 = bits [7:0].
  - When no valid data occupies a lane slot, that lane outputs 0x00. The array accumulates nothing from idle slots.
- k_len=0: no reads, arr_in stays 0, result captured after DRAIN (all PEs cleared, so 0).
- arr_clr is asserted only in CLEAR, never concurrently with a valid data lane.
- Latency, start accepted at cycle t: CLEAR t+1; first read t+2; last read t+1+k_len; res_valid rises at t+2+k_len+DRAIN_CYC.
- No arithmetic on data. Address counter width ADDR_W, no wrap within a job.

Test Plan:
- Reset: assert rst_n=1 mid-FEED with k_len=20 -> all outputs 0 immediately (async), state IDLE, no done. After release, start works normally.
- k_len=4: A words 0x01020304 x4, B words 0x01010101 x4, start at cycle 0 -> arr_clr at cycle 1; addresses 0..3 at cycles 2..5. arr_in_a lane0=0x01 on cycles 4..7 and lane3=0x04 on cycles 7..10, zeros elsewhere. res_valid at cycle 16 with res_data equal to the arr_out_c sample.
- Backpressure: hold res_ready=0 for 5 cycles in OUT -> res_valid and res_data stable. Release -> done pulses exactly 1 cycle with res_valid=0.
- Start while busy: pulse start during FEED, DRAIN and the handshake cycle -> ignored, k_len unchanged. Start one cycle after done -> accepted, busy=1.
- k_len=0 -> arr_clr, no buf_rd_en, arr_in all 0. res_valid at start+2+DRAIN_CYC.
- Back-to-back jobs k_len=255 then k_len=1 -> addresses reach 0xFE without wrap. The second job restarts at address 0 with arr_clr asserted.
